// File: rtl/word_packer_pkg.sv
// word_packer_pkg: shared types and helpers for the word packer.
//   mode_e      - latched packing mode (raw 2'b11 decodes to CONCAT_MSB)
//   state_e     - packer FSM states
//   decode_mode - maps the raw 2-bit mode input onto mode_e
package word_packer_pkg;

  typedef enum logic [1:0] {
    CONCAT_MSB = 2'b00,
    CONCAT_LSB = 2'b01,
    REPLICATE  = 2'b10
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    FILL = 2'b01,
    HOLD = 2'b10
  } state_e;

  function automatic mode_e decode_mode(input logic [1:0] raw);
    mode_e m;
    case (raw)
      2'b01:   m = CONCAT_LSB;
      2'b10:   m = REPLICATE;
      default: m = CONCAT_MSB;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/word_packer_if.sv
// word_packer_if: handshake bundle between a producer/consumer and the packer.
//   in_data/in_valid/in_ready    - input word stream
//   mode/flush/fill_bit          - packing control
//   out_data/out_valid/out_ready - packed word stream
//   out_count                    - lanes of out_data holding real data
// master: the environment side; slave: the packer side.
interface word_packer_if #(
  parameter int IN_W  = 4,
  parameter int LANES = 4
);
  localparam int OUT_W = IN_W * LANES;
  localparam int CW    = $clog2(LANES + 1);

  logic [IN_W-1:0]  in_data;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       mode;
  logic             flush;
  logic             fill_bit;
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [CW-1:0]    out_count;

  modport master (
    output in_data, in_valid, mode, flush, fill_bit, out_ready,
    input  in_ready, out_data, out_valid, out_count
  );

  modport slave (
    input  in_data, in_valid, mode, flush, fill_bit, out_ready,
    output in_ready, out_data, out_valid, out_count
  );

endinterface

// File: rtl/word_packer_lane_cnt.sv
// word_packer_lane_cnt: counts lanes filled in the word under construction
// and decides when that word must be emitted.
//   clk, rst_n  - clock, async active-low reset
//   accept_s    - an input word is taken this cycle
//   flush_s     - raw flush request
//   repl_s      - this accept starts a replicate-mode word
//   cnt_r       - lanes already filled (0 means no word in progress)
//   done_s      - the word is emitted at the coming edge
//   emit_cnt_s  - real-data lane count of the emitted word
module word_packer_lane_cnt #(
  parameter int LANES = 4,
  parameter int CW    = $clog2(LANES + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          accept_s,
  input  logic          flush_s,
  input  logic          repl_s,
  output logic [CW-1:0] cnt_r,
  output logic          done_s,
  output logic [CW-1:0] emit_cnt_s
);

  logic flush_eff_s;
  logic last_s;

  // Full/flush decode; flush only counts while a partial word exists.
  always_comb begin
    flush_eff_s = flush_s && (cnt_r != CW'(0));
    last_s      = (cnt_r == CW'(LANES - 1));
    done_s      = 1'b0;
    emit_cnt_s  = cnt_r;
    if (accept_s && repl_s) begin
      done_s     = 1'b1;
      emit_cnt_s = CW'(LANES);
    end else if (accept_s) begin
      // The accepted word is included before any coincident flush.
      emit_cnt_s = cnt_r + CW'(1);
      done_s     = last_s || flush_eff_s;
    end else begin
      done_s     = flush_eff_s;
    end
  end

  // Lane counter: restarts at zero whenever a word is emitted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= CW'(0);
    end else if (done_s) begin
      cnt_r <= CW'(0);
    end else if (accept_s) begin
      cnt_r <= cnt_r + CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/word_packer.sv
// word_packer: packs LANES words of IN_W bits into one OUT_W-bit word.
//   clk, rst_n - clock, async active-low reset
//   bus        - word_packer_if.slave: input stream, control
//                (mode/flush/fill_bit) and packed output stream with count
// The mode is captured with the first word of each output word. A flush
// emits a partial word with unfilled lanes set to fill_bit.
module word_packer
  import word_packer_pkg::*;
#(
  parameter int IN_W  = 4,
  parameter int LANES = 4
) (
  input logic          clk,
  input logic          rst_n,
  word_packer_if.slave bus
);

  localparam int OUT_W = IN_W * LANES;
  localparam int CW    = $clog2(LANES + 1);

  state_e           state_r;
  state_e           state_nxt_s;
  mode_e            mode_r;
  mode_e            eff_mode_s;
  logic [CW-1:0]    cnt_r;
  logic [CW-1:0]    emit_cnt_s;
  logic             done_s;
  logic             accept_s;
  logic             in_ready_s;
  logic             repl_s;
  logic [IN_W-1:0]  lanes_r   [LANES];
  logic [IN_W-1:0]  lane_val_s[LANES];
  logic [OUT_W-1:0] packed_s;
  logic [OUT_W-1:0] out_data_r;
  logic [CW-1:0]    out_count_r;
  logic             out_valid_r;

  assign in_ready_s    = !out_valid_r || bus.out_ready;
  assign accept_s      = bus.in_valid && in_ready_s;
  // A fresh word (count 0) follows the live mode input; otherwise the latched one.
  assign eff_mode_s    = (cnt_r == CW'(0)) ? decode_mode(bus.mode) : mode_r;
  assign repl_s        = (cnt_r == CW'(0)) && (eff_mode_s == REPLICATE);

  assign bus.in_ready  = in_ready_s;
  assign bus.out_data  = out_data_r;
  assign bus.out_count = out_count_r;
  assign bus.out_valid = out_valid_r;

  word_packer_lane_cnt #(
    .LANES (LANES),
    .CW    (CW)
  ) u_lane_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .accept_s   (accept_s),
    .flush_s    (bus.flush),
    .repl_s     (repl_s),
    .cnt_r      (cnt_r),
    .done_s     (done_s),
    .emit_cnt_s (emit_cnt_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    if (done_s) begin
      state_nxt_s = HOLD;
    end else if (accept_s) begin
      state_nxt_s = FILL;
    end else begin
      case (state_r)
        IDLE:    state_nxt_s = IDLE;
        FILL:    state_nxt_s = FILL;
        HOLD:    state_nxt_s = bus.out_ready ? IDLE : HOLD;
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // Lane assembly in arrival order: stored lanes, the incoming word, then fill.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      if (eff_mode_s == REPLICATE) begin
        lane_val_s[i] = bus.in_data;
      end else if (i < int'(cnt_r)) begin
        lane_val_s[i] = lanes_r[i];
      end else if ((i == int'(cnt_r)) && accept_s) begin
        lane_val_s[i] = bus.in_data;
      end else begin
        lane_val_s[i] = {IN_W{bus.fill_bit}};
      end
    end
  end

  // Lane placement: arrival lane 0 lands at the MSB end unless LSB-first.
  always_comb begin
    packed_s = {OUT_W{1'b0}};
    for (int i = 0; i < LANES; i++) begin
      if (eff_mode_s == CONCAT_LSB) begin
        packed_s[i*IN_W +: IN_W] = lane_val_s[i];
      end else begin
        packed_s[(LANES-1-i)*IN_W +: IN_W] = lane_val_s[i];
      end
    end
  end

  // Partial-word storage and mode latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_r <= CONCAT_MSB;
      for (int i = 0; i < LANES; i++) begin
        lanes_r[i] <= {IN_W{1'b0}};
      end
    end else begin
      if (accept_s && (cnt_r == CW'(0))) begin
        mode_r <= eff_mode_s;
      end else begin
        mode_r <= mode_r;
      end
      for (int i = 0; i < LANES; i++) begin
        if (accept_s && !done_s && (cnt_r == CW'(i))) begin
          lanes_r[i] <= bus.in_data;
        end else begin
          lanes_r[i] <= lanes_r[i];
        end
      end
    end
  end

  // Output registers: load on emission, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_r  <= {OUT_W{1'b0}};
      out_count_r <= CW'(0);
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= (state_nxt_s == HOLD);
      if (done_s) begin
        out_data_r  <= packed_s;
        out_count_r <= emit_cnt_s;
      end else begin
        out_data_r  <= out_data_r;
        out_count_r <= out_count_r;
      end
    end
  end

endmodule

// File: tb/tb_word_packer.sv
// tb_word_packer: table-driven packing vectors plus hand-written sequences
// for backpressure, idle flush and mid-word reset; emitted words are
// compared against a scoreboard queue filled when stimulus is driven.
module tb_word_packer;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  typedef struct {
    logic [15:0] data;
    logic [2:0]  cnt;
  } exp_t;

  // fmode: 0 no flush, 1 flush on the cycle after the last word, 2 flush with last word
  typedef struct {
    logic [1:0]  mode;
    logic [15:0] words;
    int          n;
    int          fmode;
    logic        fill;
    logic [15:0] exp_data;
    logic [2:0]  exp_cnt;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[9];

  word_packer_if #(.IN_W(4), .LANES(4)) bus ();

  word_packer #(.IN_W(4), .LANES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [3:0] d, input logic fl,
                       input logic fb, input logic [1:0] m, input logic ordy);
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.flush     = fl;
    bus.fill_bit  = fb;
    bus.mode      = m;
    bus.out_ready = ordy;
  endtask

  // Observe the output handshake mid-cycle, then advance one clock.
  task automatic tick();
    exp_t e;
    #1;
    if (bus.out_valid && bus.out_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected actual=%h required=none", bus.out_data);
      end else begin
        e = sb_q.pop_front();
        check("sb_data", 32'(bus.out_data), 32'(e.data));
        check("sb_count", 32'(bus.out_count), 32'(e.cnt));
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    vecs[0] = '{2'b00, 16'hC1A5, 4, 0, 1'b0, 16'hC1A5, 3'd4};
    vecs[1] = '{2'b01, 16'hC1A5, 4, 0, 1'b0, 16'h5A1C, 3'd4};
    vecs[2] = '{2'b10, 16'h9000, 1, 0, 1'b0, 16'h9999, 3'd4};
    vecs[3] = '{2'b00, 16'hC100, 2, 1, 1'b0, 16'hC100, 3'd2};
    vecs[4] = '{2'b00, 16'hC100, 2, 1, 1'b1, 16'hC1FF, 3'd2};
    vecs[5] = '{2'b11, 16'h372E, 4, 0, 1'b0, 16'h372E, 3'd4};
    vecs[6] = '{2'b01, 16'hC100, 2, 1, 1'b1, 16'hFF1C, 3'd2};
    vecs[7] = '{2'b00, 16'hC1A0, 3, 2, 1'b0, 16'hC1A0, 3'd3};
    vecs[8] = '{2'b00, 16'hC1A5, 4, 2, 1'b1, 16'hC1A5, 3'd4};

    // Reset state
    rst_n = 1'b0;
    drive(1'b0, 4'h0, 1'b0, 1'b0, 2'b00, 1'b1);
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_data", 32'(bus.out_data), 32'h0);
    check("rst_out_valid", 32'(bus.out_valid), 32'h0);
    check("rst_out_count", 32'(bus.out_count), 32'h0);
    check("rst_in_ready", 32'(bus.in_ready), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven vectors; mid-word mode is scrambled to REPLICATE and must be ignored
    for (int v = 0; v < 9; v++) begin
      sb_q.push_back('{vecs[v].exp_data, vecs[v].exp_cnt});
      for (int k = 0; k < vecs[v].n; k++) begin
        drive(1'b1, vecs[v].words[15-4*k -: 4],
              (vecs[v].fmode == 2) && (k == vecs[v].n - 1),
              vecs[v].fill, (k == 0) ? vecs[v].mode : 2'b10, 1'b1);
        tick();
      end
      if (vecs[v].fmode == 1) begin
        drive(1'b0, 4'h0, 1'b1, vecs[v].fill, 2'b10, 1'b1);
        tick();
      end
      drive(1'b0, 4'h0, 1'b0, 1'b0, 2'b00, 1'b1);
      #1;
      check("latency_valid", 32'(bus.out_valid), 32'h1);
      tick();
    end

    // Flush while idle is ignored
    drive(1'b0, 4'h0, 1'b1, 1'b1, 2'b00, 1'b1);
    tick();
    drive(1'b0, 4'h0, 1'b0, 1'b0, 2'b00, 1'b1);
    #1;
    check("flush_idle_valid", 32'(bus.out_valid), 32'h0);
    tick();

    // Backpressure: held output, in_ready low, then restart at lane 0
    sb_q.push_back('{16'hC1A5, 3'd4});
    drive(1'b1, 4'hC, 1'b0, 1'b0, 2'b00, 1'b1); tick();
    drive(1'b1, 4'h1, 1'b0, 1'b0, 2'b00, 1'b1); tick();
    drive(1'b1, 4'hA, 1'b0, 1'b0, 2'b00, 1'b1); tick();
    drive(1'b1, 4'h5, 1'b0, 1'b0, 2'b00, 1'b1); tick();
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 4'h3, 1'b0, 1'b0, 2'b00, 1'b0);
      #1;
      check("bp_in_ready", 32'(bus.in_ready), 32'h0);
      check("bp_out_valid", 32'(bus.out_valid), 32'h1);
      check("bp_out_data", 32'(bus.out_data), 32'hC1A5);
      tick();
    end
    sb_q.push_back('{16'h2468, 3'd4});
    drive(1'b1, 4'h2, 1'b0, 1'b0, 2'b00, 1'b1); tick();
    drive(1'b1, 4'h4, 1'b0, 1'b0, 2'b00, 1'b1); tick();
    drive(1'b1, 4'h6, 1'b0, 1'b0, 2'b00, 1'b1); tick();
    drive(1'b1, 4'h8, 1'b0, 1'b0, 2'b00, 1'b1); tick();
    drive(1'b0, 4'h0, 1'b0, 1'b0, 2'b00, 1'b1);
    #1;
    check("bp_restart_valid", 32'(bus.out_valid), 32'h1);
    tick();

    // Reset mid-word discards C,1
    drive(1'b1, 4'hC, 1'b0, 1'b0, 2'b00, 1'b1); tick();
    drive(1'b1, 4'h1, 1'b0, 1'b0, 2'b00, 1'b1); tick();
    drive(1'b0, 4'h0, 1'b0, 1'b0, 2'b00, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_data", 32'(bus.out_data), 32'h0);
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'h0);
    check("mid_rst_out_count", 32'(bus.out_count), 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    sb_q.push_back('{16'hA537, 3'd4});
    drive(1'b1, 4'hA, 1'b0, 1'b0, 2'b00, 1'b1); tick();
    drive(1'b1, 4'h5, 1'b0, 1'b0, 2'b00, 1'b1); tick();
    drive(1'b1, 4'h3, 1'b0, 1'b0, 2'b00, 1'b1); tick();
    drive(1'b1, 4'h7, 1'b0, 1'b0, 2'b00, 1'b1); tick();
    drive(1'b0, 4'h0, 1'b0, 1'b0, 2'b00, 1'b1);
    #1;
    check("post_rst_valid", 32'(bus.out_valid), 32'h1);
    tick();
    tick();

    check("sb_empty", 32'(sb_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/word_packer.md
WORD_PACKER -- requirements
Module: word_packer

Interface
REQ-001 SHALL have parameter IN_W, default 4, giving the input word width in bits (1..32).
REQ-002 SHALL have parameter LANES, default 4, giving the number of input words per output word (2..16).
REQ-003 SHALL have local parameter OUT_W = IN_W*LANES and CW = $clog2(LANES+1).
REQ-004 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port in_data  input  IN_W  word to pack.
REQ-007 SHALL have port in_valid  input  1  in_data valid.
REQ-008 SHALL have port in_ready  output  1  packer can accept in_data.
REQ-009 SHALL have port mode  input  2  00 concat MSB-first, 01 concat LSB-first, 10 replicate, 11 treated as 00.
REQ-010 SHALL have port flush  input  1  emit a partially filled word.
REQ-011 SHALL have port fill_bit  input  1  value written to every bit of unfilled lanes on flush.
REQ-012 SHALL have port out_data  output  OUT_W  packed word.
REQ-013 SHALL have port out_valid  output  1  out_data valid.
REQ-014 SHALL have port out_ready  input  1  consumer accepts out_data.
REQ-015 SHALL have port out_count  output  CW  number of lanes carrying real data in out_data.

Function
REQ-016 SHALL accept an input word only when in_valid && in_ready, and SHALL drive in_ready = !out_valid || out_ready.
REQ-017 SHALL sample mode when the first word of an output word is accepted (lane count 0) and hold it until that word is emitted; mode changes mid-word SHALL be ignored.
REQ-018 SHALL, in MSB-first mode, produce out_data = {w0, w1, ..., wLANES-1}, with w0 as the first accepted word.
REQ-019 SHALL, in LSB-first mode, produce out_data = {wLANES-1, ..., w1, w0}.
REQ-020 SHALL, in replicate mode, emit {LANES{w0}} with out_count = LANES after a single accepted word.
REQ-021 SHALL assert out_valid on the cycle after the completing word is accepted (latency 1), with out_count = LANES.
REQ-022 SHALL use states IDLE (count 0), FILL (0<count<LANES) and HOLD (out_valid=1), with transitions IDLE->FILL on accept, FILL->HOLD on the completing accept or flush, and HOLD->IDLE on out_ready, or HOLD->FILL on out_ready with a same-cycle accept.
REQ-023 SHALL, on flush in FILL, emit on the next cycle with out_count = current count and unfilled lanes = {IN_W{fill_bit}}; flush in IDLE or HOLD SHALL be ignored.
REQ-024 SHALL, when flush coincides with an accept, include that word first, then flush; if that word completes the output, the result SHALL be a normal full emission.
REQ-025 SHALL hold out_data, out_count and out_valid stable while out_valid && !out_ready.
REQ-026 SHALL never leave an output bit undriven or X after reset; all lanes SHALL be defined.

Reset
REQ-027 SHALL, while rst_n=0, force out_data=0, out_valid=0, out_count=0, lane count=0, state=IDLE, and latched mode=00.
REQ-028 SHALL discard a partially packed word on reset assertion mid-operation and SHALL NOT emit it after release.
REQ-029 SHALL accept input on the first rising clk edge after rst_n deasserts.

Structure
REQ-030 SHALL place the mode enum (CONCAT_MSB, CONCAT_LSB, REPLICATE) and the state enum in package word_packer_pkg.
REQ-031 SHALL implement the lane counter with its full/flush decode as a sub-module word_packer_lane_cnt; lane placement SHALL remain in word_packer.

Verification (IN_W=4, LANES=4)
REQ-032 SHALL verify MSB-first: words C,1,A,5 on consecutive cycles -> out_data=16'hC1A5, out_count=4, out_valid one cycle after the word 5.
REQ-033 SHALL verify LSB-first with the same words -> out_data=16'h5A1C; replicate with word 9 -> 16'h9999, out_count=4.
REQ-034 SHALL verify flush after C,1 in MSB-first mode: fill_bit=0 -> 16'hC100, out_count=2; fill_bit=1 -> 16'hC1FF.
REQ-035 SHALL verify backpressure: out_ready=0 for 3 cycles -> in_ready=0 and out_data stable; out_ready=1 together with in_valid -> new word starts at lane 0.
REQ-036 SHALL verify reset mid-word: C,1 accepted, rst_n pulsed low -> outputs zero; then A,5,3,7 -> 16'hA537, no residue of C,1.
